uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter (the uart_byte_tx companion of uart_byte_rx) between N_REQ independent requesters.
- Requesters include string detectors, status reporters and echo logic.
- Grants are round-robin at message granularity. A granted requester keeps the transmitter until it delivers a byte flagged last, so multi-byte messages (e.g. "hello\r\n") are never interleaved.
- A hold timeout releases a stalled owner.

---
 rtl/uart_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and helpers for the UART transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    BUSY  = 2'd3
  } arb_state_e;

  // Index width that stays legal even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  typedef logic [ID_W-1:0] id_t;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx = '0;
    any = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        idx = id_t'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Message-granular round-robin sharing of one UART byte transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int HOLD_TO = 1023,
  parameter int TO_W    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_send_en,
  input  logic                      tx_done,
  output logic [id_width(N_REQ)-1:0] grant_id,
  output logic                      busy,
  output logic                      abort_err
);

  localparam int c_id_w = id_width(N_REQ);

  typedef logic [c_id_w-1:0] id_t;
  typedef logic [TO_W-1:0]   cnt_t;

  // Counter value on the last tolerated stall cycle.
  localparam cnt_t c_to_last = cnt_t'(HOLD_TO - 1);

  arb_state_e        r_state;
  id_t               r_ptr;
  id_t               r_grant_id;
  logic              r_busy;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_last;
  cnt_t              r_cnt;
  logic              r_abort;

  arb_state_e        w_state_nxt;
  id_t               w_ptr_nxt;
  id_t               w_grant_nxt;
  logic              w_busy_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_last_nxt;
  cnt_t              w_cnt_nxt;
  logic              w_abort_nxt;

  id_t               w_pick_idx;
  logic              w_pick_any;
  id_t               w_ptr_inc;
  logic              w_owner_valid;
  logic              w_owner_last;
  logic [DATA_W-1:0] w_owner_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (c_id_w)
  ) u_pick (
    .req (req_valid),
    .ptr (r_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign w_ptr_inc     = id_t'(next_ptr(int'(r_grant_id), N_REQ));
  assign w_owner_valid = req_valid[r_grant_id];
  assign w_owner_last  = req_last[r_grant_id];
  assign w_owner_data  = req_data[int'(r_grant_id)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_tx_data  <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_data  <= w_data_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant_id;
    w_busy_nxt  = r_busy;
    w_data_nxt  = r_tx_data;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = 1'b0;
    req_ready   = '0;

    unique case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
          w_busy_nxt  = 1'b1;
          w_state_nxt = GRANT;
        end
      end

      GRANT: begin
        req_ready[r_grant_id] = w_owner_valid;
        if (w_owner_valid) begin
          w_data_nxt  = w_owner_data;
          w_last_nxt  = w_owner_last;
          w_cnt_nxt   = '0;
          w_state_nxt = SEND;
        end else if (r_cnt == c_to_last) begin
          // Stalled owner: drop the partial message and move the pointer on.
          w_abort_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = w_ptr_inc;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end
      end

      SEND: begin
        w_state_nxt = BUSY;
      end

      BUSY: begin
        if (tx_done) begin
          if (r_last) begin
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = w_ptr_inc;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = GRANT;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign tx_send_en = (r_state == SEND);
  assign tx_data    = r_tx_data;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;
  assign abort_err  = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Randomised and directed checking of uart_tx_arbiter against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int HT = 5;
  localparam int TW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_send_en;
  logic           tx_done = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;
  logic           abort_err;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .DATA_W  (W),
    .HOLD_TO (HT),
    .TO_W    (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_send_en (tx_send_en),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .busy       (busy),
    .abort_err  (abort_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Requester sources, transmitter model and event logs
  logic [8:0] q[N][$];
  int  hold[N];
  bit  stall_once[N];
  bit  rnd = 1'b0;
  int  tx_delay = 10;
  int  done_at = -1;
  int  log_id[$], log_data[$], ready_cyc[$], send_cyc[$], done_cyc[$], abort_cyc[$];
  int  fall_cyc = -1;
  bit  prev_busy = 1'b0;

  // Reference model: owner/pointer bookkeeping straight from the arbitration rules
  bit m_on = 1'b0;
  int m_owner = -1, m_gid = 0, m_ptr = 0, m_stall = 0, m_data = 0;
  bit m_offer = 0, m_send = 0, m_flight = 0, m_last = 0, m_abort = 0;

  always @(negedge clk) begin : model
    logic [N-1:0] er;
    if (m_on) begin
      er = '0;
      if (m_offer && req_valid[m_owner]) er[m_owner] = 1'b1;
      chk("busy", busy, (m_owner >= 0));
      if (m_owner >= 0) chk("grant_id", grant_id, m_gid);
      chk("req_ready", req_ready, er);
      chk("tx_send_en", tx_send_en, m_send);
      chk("tx_data", tx_data, m_data);
      chk("abort_err", abort_err, m_abort);
    end
    if (reset) begin
      m_on = 1; m_owner = -1; m_gid = 0; m_ptr = 0; m_stall = 0; m_data = 0;
      m_offer = 0; m_send = 0; m_flight = 0; m_last = 0; m_abort = 0;
    end else if (m_on) begin
      m_abort = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_gid = m_owner; m_offer = 1; m_stall = 0;
          end
        end
      end else if (m_offer) begin
        if (req_valid[m_owner]) begin
          m_data = int'(req_data[m_owner*W +: W]);
          m_last = req_last[m_owner];
          m_offer = 0; m_send = 1; m_stall = 0;
        end else begin
          m_stall++;
          if (m_stall == HT) begin
            m_abort = 1; m_ptr = (m_owner + 1) % N;
            m_owner = -1; m_offer = 0; m_stall = 0;
          end
        end
      end else if (m_send) begin
        m_send = 0; m_flight = 1;
      end else if (m_flight && tx_done) begin
        m_flight = 0;
        if (m_last) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          m_offer = 1;
        end
      end
    end
  end

  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    if (|req_ready) ready_cyc.push_back(cyc);
    if (tx_send_en) begin
      log_id.push_back(int'(grant_id));
      log_data.push_back(int'(tx_data));
      send_cyc.push_back(cyc);
      done_at = cyc + ((tx_delay > 0) ? tx_delay : int'($urandom_range(1, 12)));
    end
    if (tx_done)   done_cyc.push_back(cyc);
    if (abort_err) abort_cyc.push_back(cyc);
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && q[i].size() > 0) begin
        void'(q[i].pop_front());
        if (stall_once[i]) begin
          hold[i] = 30;
          stall_once[i] = 1'b0;
        end else if (rnd && $urandom_range(0, 3) == 0) begin
          hold[i] = int'($urandom_range(1, 7));
        end
      end else if (rnd && $urandom_range(0, 15) == 0) begin
        hold[i] = 2;
      end
      if (hold[i] > 0) begin
        hold[i]--;
        req_valid[i] = 1'b0;
      end else begin
        req_valid[i] = (q[i].size() > 0);
      end
      if (q[i].size() > 0) begin
        req_data[i*W +: W] = q[i][0][7:0];
        req_last[i]        = q[i][0][8];
      end
    end
    tx_done = (cyc == done_at);
  endtask

  task automatic load(input int i, input int data, input int last);
    logic [8:0] v;
    v = {last[0], data[7:0]};
    q[i].push_back(v);
  endtask

  task automatic clear_logs();
    log_id.delete(); log_data.delete(); ready_cyc.delete();
    send_cyc.delete(); done_cyc.delete(); abort_cyc.delete();
    fall_cyc = -1;
  endtask

  task automatic run_idle(input int budget);
    int n;
    bit pend;
    n = 0;
    do begin
      tick();
      n++;
      pend = busy || (done_at >= cyc);
      for (int i = 0; i < N; i++) if (q[i].size() > 0) pend = 1'b1;
    end while (pend && n < budget);
    chk("drain_within_budget", (n < budget), 1);
    tick();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      q[i].delete(); hold[i] = 0; stall_once[i] = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    done_at = -1;
    clear_logs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_d[6];
    int exp_i[6];
    for (int i = 0; i < N; i++) begin hold[i] = 0; stall_once[i] = 1'b0; end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_tx_send_en", tx_send_en, 0);
    chk("reset_abort_err", abort_err, 0);
    clear_logs();

    // 1: "hi" from requester 1, done 10 cycles after each send
    tx_delay = 10;
    load(1, 8'h68, 0);
    load(1, 8'h69, 1);
    run_idle(200);
    chk("t1_sends", send_cyc.size(), 2);
    if (send_cyc.size() == 2) begin
      chk("t1_byte0", log_data[0], 8'h68);
      chk("t1_byte1", log_data[1], 8'h69);
      chk("t1_owner", log_id[1], 1);
    end
    if (done_cyc.size() == 2) chk("t1_busy_fall", fall_cyc, done_cyc[1] + 1);
    else chk("t1_dones", done_cyc.size(), 2);
    // pointer must now be 2: requesters 1 and 2 together give 2 first
    clear_logs();
    load(1, 8'h01, 1);
    load(2, 8'h02, 1);
    run_idle(200);
    chk("t1_ptr_sends", log_id.size(), 2);
    if (log_id.size() == 2) begin
      chk("t1_ptr_first", log_id[0], 2);
      chk("t1_ptr_second", log_id[1], 1);
    end

    // 2: contention between requesters 0 and 2
    do_reset();
    tx_delay = 3;
    for (int k = 0; k < 3; k++) begin
      load(0, 8'h10 + k, (k == 2) ? 1 : 0);
      load(2, 8'h20 + k, (k == 2) ? 1 : 0);
    end
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    exp_i = '{0, 0, 0, 2, 2, 2};
    run_idle(300);
    chk("t2_sends", log_data.size(), 6);
    if (log_data.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t2_data", log_data[k], exp_d[k]);
        chk("t2_owner", log_id[k], exp_i[k]);
      end
    end

    // 3: fairness with continuously valid single-byte messages
    do_reset();
    tx_delay = 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) load(i, 8'h30 + 4*r + i, 1);
    run_idle(300);
    chk("t3_sends", log_id.size(), 8);
    chk("t3_ready_pulses", ready_cyc.size(), 8);
    if (log_id.size() == 8)
      for (int k = 0; k < 8; k++) chk("t3_order", log_id[k], k % N);

    // 4: owner stalls mid-message, hold timeout = 5
    do_reset();
    tx_delay = 4;
    load(0, 8'hA0, 0);
    load(0, 8'hA1, 1);
    load(1, 8'hB0, 1);
    stall_once[0] = 1'b1;
    run_idle(400);
    chk("t4_aborts", abort_cyc.size(), 1);
    if (abort_cyc.size() == 1 && done_cyc.size() > 0)
      chk("t4_abort_latency", abort_cyc[0] - done_cyc[0], 6);
    chk("t4_sends", log_id.size(), 3);
    if (log_id.size() == 3) begin
      chk("t4_next_owner", log_id[1], 1);
      chk("t4_next_data", log_data[1], 8'hB0);
      chk("t4_resume_data", log_data[2], 8'hA1);
    end

    // 5: reset while a byte is in flight, stray tx_done afterwards
    do_reset();
    tx_delay = 60;
    load(3, 8'h55, 1);
    for (int k = 0; k < 20 && send_cyc.size() == 0; k++) tick();
    tick();
    tick();
    chk("t5_busy_before", busy, 1);
    for (int i = 0; i < N; i++) q[i].delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    done_at = cyc + 3;
    clear_logs();
    chk("t5_busy", busy, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_tx_data", tx_data, 0);
    chk("t5_send", tx_send_en, 0);
    chk("t5_ready", req_ready, 0);
    repeat (8) tick();
    chk("t5_no_send", send_cyc.size(), 0);
    chk("t5_stray_done_seen", done_cyc.size(), 1);
    chk("t5_idle_after", busy, 0);

    // 6: back-to-back 5-byte message
    do_reset();
    tx_delay = 4;
    for (int k = 0; k < 5; k++) load(2, 8'h40 + k, (k == 4) ? 1 : 0);
    run_idle(300);
    chk("t6_sends", send_cyc.size(), 5);
    chk("t6_readies", ready_cyc.size(), 5);
    if (send_cyc.size() == 5 && ready_cyc.size() == 5 && done_cyc.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("t6_send_after_ready", send_cyc[k] - ready_cyc[k], 1);
      for (int k = 1; k < 5; k++) chk("t6_ready_after_done", ready_cyc[k] - done_cyc[k-1], 1);
    end

    // 7: randomised traffic with stalls, checked cycle by cycle by the model
    do_reset();
    rnd = 1'b1;
    tx_delay = 0;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        int r, len;
        r = int'($urandom_range(0, N - 1));
        len = int'($urandom_range(1, 4));
        for (int k = 0; k < len; k++) load(r, int'($urandom_range(0, 255)), (k == len - 1) ? 1 : 0);
      end
      tick();
    end
    run_idle(4000);
    rnd = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
